// File: rtl/sysbus_pkg.sv
// Sysbus constants and cache controller state encoding shared by the cache slice.
package sysbus_pkg;

    localparam int SYSBUS_TAG_W    = 13;
    localparam int SYSBUS_READ_BIT = 12;

    localparam logic [3:0] SYSBUS_MEMORY = 4'b0001;

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] LOOKUP   = 3'd1;
    localparam logic [2:0] FILL_REQ = 3'd2;
    localparam logic [2:0] FILL     = 3'd3;
    localparam logic [2:0] RESP     = 3'd4;

    function automatic logic [SYSBUS_TAG_W-1:0] fill_tag();
        return {1'b1, SYSBUS_MEMORY, 8'b0};
    endfunction

endpackage

// File: rtl/cache_line_ram.sv
// Line storage for the direct-mapped cache: one data beat per (index, beat) plus one tag per index.
module cache_line_ram #(
    parameter int DATA_W  = 64,
    parameter int TAG_W   = 50,
    parameter int INDEX_W = 8,
    parameter int BEAT_W  = 3
) (
    input  logic               clk,
    input  logic               data_we,
    input  logic               tag_we,
    input  logic [INDEX_W-1:0] windex,
    input  logic [BEAT_W-1:0]  wbeat,
    input  logic [DATA_W-1:0]  wdata,
    input  logic [TAG_W-1:0]   wtag,
    input  logic [INDEX_W-1:0] rindex,
    input  logic [BEAT_W-1:0]  rbeat,
    output logic [DATA_W-1:0]  rdata,
    output logic [TAG_W-1:0]   rtag
);

    logic [DATA_W-1:0] data_mem [2**(INDEX_W+BEAT_W)];
    logic [TAG_W-1:0]  tag_mem  [2**INDEX_W];

    always_ff @(posedge clk) begin
        if (data_we) data_mem[{windex, wbeat}] <= wdata;
        if (tag_we)  tag_mem[windex]           <= wtag;
    end

    assign rdata = data_mem[{rindex, rbeat}];
    assign rtag  = tag_mem[rindex];

endmodule

// File: rtl/direct_mapped_cache.sv
// Read-allocate direct-mapped line cache between the core fetch port and the Sysbus memory port.
module direct_mapped_cache
    import sysbus_pkg::*;
#(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int NUM_SETS       = 256,
    parameter int LINE_BEATS     = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      p_bus_reqcyc,
    input  logic [BUS_DATA_WIDTH-1:0] p_bus_req,
    input  logic [BUS_TAG_WIDTH-1:0]  p_bus_reqtag,
    output logic                      p_bus_reqack,
    output logic                      p_bus_respcyc,
    output logic [BUS_DATA_WIDTH-1:0] p_bus_resp,
    output logic [BUS_TAG_WIDTH-1:0]  p_bus_resptag,
    input  logic                      p_bus_respack,
    output logic                      m_bus_reqcyc,
    output logic [BUS_DATA_WIDTH-1:0] m_bus_req,
    output logic [BUS_TAG_WIDTH-1:0]  m_bus_reqtag,
    input  logic                      m_bus_reqack,
    input  logic                      m_bus_respcyc,
    input  logic [BUS_DATA_WIDTH-1:0] m_bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]  m_bus_resptag,
    output logic                      m_bus_respack
);

    localparam int OFFSET_W = 6;
    localparam int INDEX_W  = $clog2(NUM_SETS);
    localparam int BEAT_W   = $clog2(LINE_BEATS);
    localparam int TAG_W    = BUS_DATA_WIDTH - OFFSET_W - INDEX_W;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_BEATS - 1);

    logic [2:0]                state;
    logic [BEAT_W-1:0]         cnt;
    logic [NUM_SETS-1:0]       valid;
    logic [BUS_DATA_WIDTH-1:0] addr;
    logic [BUS_TAG_WIDTH-1:0]  tag_q;

    logic [INDEX_W-1:0] req_index;
    logic [TAG_W-1:0]   req_tag;
    logic [INDEX_W-1:0] wr_index;
    logic               is_read;
    logic               hit;
    logic               fill_we;
    logic [BUS_DATA_WIDTH-1:0] rdata;
    logic [TAG_W-1:0]          rtag;
    logic               unused_bits;

    assign req_index = addr[OFFSET_W +: INDEX_W];
    assign req_tag   = addr[BUS_DATA_WIDTH-1 -: TAG_W];
    assign wr_index  = p_bus_req[OFFSET_W +: INDEX_W];
    assign is_read   = p_bus_reqtag[SYSBUS_READ_BIT];
    assign hit       = valid[req_index] && (rtag == req_tag);
    assign fill_we   = reset && (state == FILL) && m_bus_respcyc;

    cache_line_ram #(
        .DATA_W  (BUS_DATA_WIDTH),
        .TAG_W   (TAG_W),
        .INDEX_W (INDEX_W),
        .BEAT_W  (BEAT_W)
    ) u_ram (
        .clk     (clk),
        .data_we (fill_we),
        .tag_we  (fill_we && (cnt == LAST_BEAT)),
        .windex  (req_index),
        .wbeat   (cnt),
        .wdata   (m_bus_resp),
        .wtag    (req_tag),
        .rindex  (req_index),
        .rbeat   (cnt),
        .rdata   (rdata),
        .rtag    (rtag)
    );

    // Outputs are forced quiet while reset is held so an aborted transfer never leaks a beat.
    always_comb begin
        p_bus_reqack  = 1'b0;
        p_bus_respcyc = 1'b0;
        p_bus_resp    = '0;
        p_bus_resptag = '0;
        m_bus_reqcyc  = 1'b0;
        m_bus_req     = '0;
        m_bus_reqtag  = '0;
        m_bus_respack = 1'b0;
        if (reset) begin
            case (state)
                IDLE: begin
                    m_bus_respack = m_bus_respcyc;
                    if (p_bus_reqcyc) begin
                        if (is_read) begin
                            p_bus_reqack = 1'b1;
                        end else begin
                            m_bus_reqcyc = 1'b1;
                            m_bus_req    = p_bus_req;
                            m_bus_reqtag = p_bus_reqtag;
                            p_bus_reqack = m_bus_reqack;
                        end
                    end
                end
                FILL_REQ: begin
                    m_bus_reqcyc = 1'b1;
                    m_bus_req    = {addr[BUS_DATA_WIDTH-1:OFFSET_W], OFFSET_W'(0)};
                    m_bus_reqtag = BUS_TAG_WIDTH'(fill_tag());
                end
                FILL: m_bus_respack = m_bus_respcyc;
                RESP: begin
                    p_bus_respcyc = 1'b1;
                    p_bus_resp    = rdata;
                    p_bus_resptag = tag_q;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            valid <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (p_bus_reqcyc && is_read)           state <= LOOKUP;
                    else if (p_bus_reqcyc && m_bus_reqack) valid[wr_index] <= 1'b0;
                end
                LOOKUP:   state <= hit ? RESP : FILL_REQ;
                FILL_REQ: if (m_bus_reqack) state <= FILL;
                FILL: begin
                    if (m_bus_respcyc) begin
                        if (cnt == LAST_BEAT) begin
                            cnt              <= '0;
                            valid[req_index] <= 1'b1;
                            state            <= RESP;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                RESP: begin
                    if (p_bus_respack) begin
                        if (cnt == LAST_BEAT) begin
                            cnt   <= '0;
                            state <= IDLE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && p_bus_reqcyc && is_read) begin
            addr  <= p_bus_req;
            tag_q <= p_bus_reqtag;
        end
    end

    assign unused_bits = ^{addr[OFFSET_W-1:0], m_bus_resptag};

endmodule

// File: tb/tb_direct_mapped_cache.sv
// Randomized scoreboard bench for direct_mapped_cache with a line-level cache and memory model.
module tb_direct_mapped_cache;

    localparam int NSETS = 256;

    typedef struct { logic [63:0] d; logic [12:0] t; } beat_t;
    typedef struct { logic [63:0] a; logic [12:0] t; } wr_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        p_bus_reqcyc = 1'b0;
    logic [63:0] p_bus_req = '0;
    logic [12:0] p_bus_reqtag = '0;
    logic        p_bus_reqack;
    logic        p_bus_respcyc;
    logic [63:0] p_bus_resp;
    logic [12:0] p_bus_resptag;
    logic        p_bus_respack = 1'b0;
    logic        m_bus_reqcyc;
    logic [63:0] m_bus_req;
    logic [12:0] m_bus_reqtag;
    logic        m_bus_reqack = 1'b0;
    logic        m_bus_respcyc = 1'b0;
    logic [63:0] m_bus_resp = '0;
    logic [12:0] m_bus_resptag = '0;
    logic        m_bus_respack;

    direct_mapped_cache dut (
        .clk(clk), .reset(reset),
        .p_bus_reqcyc(p_bus_reqcyc), .p_bus_req(p_bus_req), .p_bus_reqtag(p_bus_reqtag),
        .p_bus_reqack(p_bus_reqack), .p_bus_respcyc(p_bus_respcyc), .p_bus_resp(p_bus_resp),
        .p_bus_resptag(p_bus_resptag), .p_bus_respack(p_bus_respack),
        .m_bus_reqcyc(m_bus_reqcyc), .m_bus_req(m_bus_req), .m_bus_reqtag(m_bus_reqtag),
        .m_bus_reqack(m_bus_reqack), .m_bus_respcyc(m_bus_respcyc), .m_bus_resp(m_bus_resp),
        .m_bus_resptag(m_bus_resptag), .m_bus_respack(m_bus_respack)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    beat_t       exp_q[$];
    wr_t         wr_exp_q[$];
    logic [63:0] fill_exp_q[$];
    logic [63:0] mem_q[$];

    bit          mv[NSETS];
    logic [49:0] mt[NSETS];
    logic [63:0] md[NSETS][8];

    int acc_cyc = 0;
    bit chk_lat = 0;
    bit hold_mode = 0;
    int beat_idx = 0;
    int hold_cnt = 0;
    int abort_at = -1;
    bit mem_paused = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag_fail(input string name, input logic [63:0] act);
        tests++;
        fails++;
        $display("FAIL %s: got 0x%0h, expected nothing (cycle %0d)", name, act, cyc);
    endtask

    // Core-side response monitor: pops expected beats when the core consumes them.
    initial begin : monitor
        forever begin
            @(negedge clk);
            #1;
            if (hold_mode && beat_idx == 2) p_bus_respack = (hold_cnt >= 3);
            else                            p_bus_respack = ($urandom_range(0, 3) != 0);
            #1;
            if (p_bus_respcyc) begin
                if (chk_lat) begin
                    check("hit_latency", 64'(cyc - acc_cyc), 64'd2);
                    chk_lat = 0;
                end
                if (exp_q.size() == 0) begin
                    flag_fail("unexpected_beat", p_bus_resp);
                end else begin
                    check("resp_data", p_bus_resp, exp_q[0].d);
                    check("resp_tag", 64'(p_bus_resptag), 64'(exp_q[0].t));
                    if (p_bus_respack) begin
                        void'(exp_q.pop_front());
                        beat_idx = (beat_idx + 1) % 8;
                        hold_cnt = 0;
                    end else if (hold_mode && beat_idx == 2) begin
                        hold_cnt++;
                    end
                end
            end else begin
                check("resp_idle_zero", 64'(|{p_bus_resp, p_bus_resptag}), 64'd0);
            end
        end
    end

    task automatic mem_step();
        @(negedge clk);
        #1;
        m_bus_reqack  = 1'b0;
        m_bus_respcyc = 1'b0;
        m_bus_resp    = '0;
    endtask

    // Memory-side model: acks forwarded writes, serves line fills from mem_q.
    initial begin : memory
        logic [63:0] fa;
        wr_t w;
        forever begin
            mem_step();
            if (m_bus_reqcyc && m_bus_reqtag[12]) begin
                if (fill_exp_q.size() == 0) flag_fail("unexpected_fill", m_bus_req);
                else begin
                    fa = fill_exp_q.pop_front();
                    check("fill_addr", m_bus_req, fa);
                end
                check("fill_tag", 64'(m_bus_reqtag), 64'h1100);
                repeat ($urandom_range(0, 2)) begin
                    mem_step();
                    check("fill_req_held", 64'(m_bus_reqcyc), 64'd1);
                end
                m_bus_reqack = 1'b1;
                repeat ($urandom_range(0, 3)) mem_step();
                for (int b = 0; b < 8; b++) begin
                    mem_step();
                    if ($urandom_range(0, 3) == 0) mem_step();
                    if (b == abort_at) begin
                        mem_paused = 1;
                        wait (reset == 1'b0);
                        wait (reset == 1'b1);
                        abort_at = -1;
                        mem_step();
                        mem_paused = 0;
                    end
                    m_bus_respcyc = 1'b1;
                    m_bus_resptag = 13'($urandom);
                    if (mem_q.size() != 0) m_bus_resp = mem_q.pop_front();
                    #1;
                    check("fill_respack", 64'(m_bus_respack), 64'd1);
                end
            end else if (m_bus_reqcyc) begin
                if (wr_exp_q.size() == 0) flag_fail("unexpected_write", m_bus_req);
                else begin
                    w = wr_exp_q.pop_front();
                    check("wr_addr", m_bus_req, w.a);
                    check("wr_tag", 64'(m_bus_reqtag), 64'(w.t));
                end
                repeat ($urandom_range(0, 2)) begin
                    mem_step();
                    check("wr_ack_wait", 64'(p_bus_reqack), 64'd0);
                end
                m_bus_reqack = 1'b1;
            end else begin
                check("mreq_idle_zero", 64'(|{m_bus_req, m_bus_reqtag}), 64'd0);
            end
        end
    end

    task automatic issue(input logic [63:0] a, input logic [12:0] t);
        bit ok = 0;
        @(negedge clk);
        p_bus_reqcyc = 1'b1;
        p_bus_req    = a;
        p_bus_reqtag = t;
        for (int n = 0; n < 100; n++) begin
            #2;
            if (p_bus_reqack) begin
                acc_cyc = cyc;
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        check("req_accept", 64'(ok), 64'd1);
        @(negedge clk);
        p_bus_reqcyc = 1'b0;
        p_bus_req    = '0;
        p_bus_reqtag = '0;
    endtask

    task automatic do_read(input logic [63:0] a, input logic [12:0] t, input bit fixed, input bit wait_done);
        int idx = int'(a[13:6]);
        logic [49:0] tg = a[63:14];
        logic [63:0] d;
        bit hit = mv[idx] && (mt[idx] == tg);
        int n = 0;
        if (!hit) begin
            fill_exp_q.push_back({a[63:6], 6'b0});
            for (int i = 0; i < 8; i++) begin
                d = fixed ? 64'h10 + 64'(i) : {$urandom, $urandom};
                mem_q.push_back(d);
                md[idx][i] = d;
            end
            mv[idx] = 1;
            mt[idx] = tg;
        end
        for (int i = 0; i < 8; i++) exp_q.push_back('{md[idx][i], t});
        chk_lat = hit;
        issue(a, t);
        if (wait_done) begin
            while (exp_q.size() != 0 && n < 400) begin
                @(negedge clk);
                n++;
            end
            check("read_complete", 64'(exp_q.size()), 64'd0);
            exp_q.delete();
            beat_idx = 0;
            chk_lat = 0;
        end
    endtask

    task automatic do_write(input logic [63:0] a, input logic [12:0] t);
        wr_exp_q.push_back('{a, t});
        mv[int'(a[13:6])] = 0;
        issue(a, t);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [63:0] a;
        int n;
        for (int i = 0; i < NSETS; i++) mv[i] = 0;
        repeat (2) begin
            @(negedge clk);
            #3;
            check("reset_outputs", 64'(|{p_bus_reqack, p_bus_respcyc, p_bus_resp, p_bus_resptag,
                  m_bus_reqcyc, m_bus_req, m_bus_reqtag, m_bus_respack}), 64'd0);
        end
        @(negedge clk);
        reset = 1'b1;

        do_read(64'h1000, 13'h1005, 1, 1);
        do_read(64'h1000, 13'h1022, 1, 1);
        hold_mode = 1;
        do_read(64'h1000, 13'h1033, 1, 1);
        hold_mode = 0;
        do_read(64'h1000 + NSETS * 64, 13'h1044, 0, 1);
        do_read(64'h1000, 13'h1055, 1, 1);
        do_write(64'h1000, 13'h0abc);
        do_read(64'h1000, 13'h1066, 1, 1);

        abort_at = 4;
        do_read(64'h3000, 13'h1077, 0, 0);
        n = 0;
        while (!mem_paused && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("abort_reached", 64'(mem_paused), 64'd1);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) begin
            #3;
            check("abort_reset_outputs", 64'(|{p_bus_reqack, p_bus_respcyc, p_bus_resp, p_bus_resptag,
                  m_bus_reqcyc, m_bus_req, m_bus_reqtag, m_bus_respack}), 64'd0);
            @(negedge clk);
        end
        exp_q.delete();
        beat_idx = 0;
        chk_lat = 0;
        for (int i = 0; i < NSETS; i++) mv[i] = 0;
        reset = 1'b1;
        n = 0;
        while ((mem_paused || mem_q.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        check("stale_drained", 64'(mem_q.size()), 64'd0);
        abort_at = -1;
        do_read(64'h1000, 13'h1088, 1, 1);

        for (int k = 0; k < 60; k++) begin
            a = (64'($urandom_range(0, 2)) << 14) | (64'($urandom_range(0, 3) * 85) << 6)
                | 64'($urandom_range(0, 63));
            if ($urandom_range(0, 5) == 0) do_write(a, {1'b0, 12'($urandom)});
            else                           do_read(a, {1'b1, 12'($urandom)}, 0, 1);
        end

        repeat (4) @(negedge clk);
        check("fills_consumed", 64'(fill_exp_q.size()), 64'd0);
        check("writes_consumed", 64'(wr_exp_q.size()), 64'd0);
        check("mem_beats_consumed", 64'(mem_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
